// File: rtl/mlp_pkg.sv
// Shared types and Q1.15 arithmetic constants for the streaming two-layer MLP engine.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FC1,
        S_FC2,
        S_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_LEAKY    = 2'd2,
        ACT_RELU_ALT = 2'd3
    } act_mode_t;

    localparam int                FRAC_BITS   = 15;
    localparam logic signed [15:0] Q15_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN    = 16'sh8000;
    localparam int                ROUND_CONST = 1 << (FRAC_BITS - 1);

endpackage

// File: rtl/mlp_mac_sat.sv
// Multiply-accumulate with bias add, round-half-up to Q1.15 and saturation.
module mlp_mac_sat
    import mlp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mac_en,
    input  logic                         bias_en,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    input  logic signed [DATA_WIDTH-1:0] a_data,
    output logic signed [DATA_WIDTH-1:0] r
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(Q15_MAX);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(Q15_MIN);

    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod    = w_data * a_data;
    // The bias word shares the weight bus, so it is aligned to the Q2.30 accumulator here.
    assign sum     = acc + (ACC_WIDTH'(w_data) <<< FRAC_BITS) + ACC_WIDTH'(ROUND_CONST);
    assign shifted = sum >>> FRAC_BITS;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        r = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_HI)
            r = SAT_HI[DATA_WIDTH-1:0];
        else if (shifted < SAT_LO)
            r = SAT_LO[DATA_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (bias_en)
            acc <= '0;
        else if (mac_en)
            acc <= acc + ACC_WIDTH'(prod);
    end

endmodule

// File: rtl/mlp_stream_engine.sv
// Streaming y = W2 * act(W1 * x + b1) + b2 engine; weights arrive on a single serial bus.
module mlp_stream_engine
    import mlp_pkg::*;
#(
    parameter int D_IN       = 64,
    parameter int D_HID      = 256,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            act_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int MAXD = (D_IN > D_HID) ? D_IN : D_HID;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int XAW  = $clog2(D_IN);
    localparam int HAW  = $clog2(D_HID);

    state_t    state, state_nx;
    act_mode_t act_q;
    logic [CW-1:0] idx, row;
    logic in_fire, w_fire, is_bias, mac_en, bias_en;
    logic signed [DATA_WIDTH-1:0] operand, r, r_act;
    logic [XAW-1:0] x_addr;
    logic [HAW-1:0] h_addr;
    logic [DATA_WIDTH-1:0] x_buf [D_IN];
    logic [DATA_WIDTH-1:0] h_buf [D_HID];
    logic [DATA_WIDTH-1:0] x_rd, h_rd;

    assign in_ready  = (state == S_LOAD);
    assign w_ready   = (state == S_FC1) || (state == S_FC2);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    assign in_fire = in_valid && in_ready;
    assign w_fire  = w_valid && w_ready;
    // Each neuron is its input words followed by one bias word.
    assign is_bias = (state == S_FC1) ? (idx == CW'(D_IN)) : (idx == CW'(D_HID));
    assign mac_en  = w_fire && !is_bias;
    assign bias_en = w_fire && is_bias;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: if (in_fire && idx == CW'(D_IN - 1)) state_nx = S_FC1;
            S_FC1:  if (bias_en && row == CW'(D_HID - 1)) state_nx = S_FC2;
            S_FC2:  if (bias_en) state_nx = S_OUT;
            S_OUT:  if (out_ready) state_nx = (row == CW'(D_IN - 1)) ? S_DONE : S_FC2;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            row      <= '0;
            act_q    <= ACT_NONE;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx   <= '0;
                    row   <= '0;
                    act_q <= act_mode_t'(act_mode);
                end
                S_LOAD: if (in_fire)
                    idx <= (idx == CW'(D_IN - 1)) ? '0 : idx + 1'b1;
                S_FC1: if (w_fire) begin
                    if (is_bias) begin
                        idx <= '0;
                        row <= (row == CW'(D_HID - 1)) ? '0 : row + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_FC2: if (w_fire) begin
                    if (is_bias) begin
                        idx      <= '0;
                        out_data <= r;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: if (out_ready)
                    row <= (row == CW'(D_IN - 1)) ? '0 : row + 1'b1;
                default: ;
            endcase
        end
    end

    // Single address per buffer: x_buf is written in LOAD and read in FC1; h_buf written
    // by row in FC1 and read by column in FC2.
    assign x_addr = idx[XAW-1:0];
    assign h_addr = (state == S_FC1) ? row[HAW-1:0] : idx[HAW-1:0];
    assign x_rd   = x_buf[x_addr];
    assign h_rd   = h_buf[h_addr];

    // NOTE: buffers carry no reset so they map onto RAM; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_fire)
            x_buf[x_addr] <= in_data;
        if (bias_en && state == S_FC1)
            h_buf[h_addr] <= r_act;
    end

    assign operand = (state == S_FC1) ? $signed(x_rd) : $signed(h_rd);

    mlp_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .mac_en  (mac_en),
        .bias_en (bias_en),
        .w_data  ($signed(w_data)),
        .a_data  (operand),
        .r       (r)
    );

    always_comb begin
        r_act = r;
        case (act_q)
            ACT_RELU, ACT_RELU_ALT: if (r < 0) r_act = '0;
            ACT_LEAKY:              if (r < 0) r_act = r >>> 3;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mlp_stream_engine.sv
// Scoreboard bench for mlp_stream_engine at D_IN=2, D_HID=2: a reference model queues y, the monitor compares.
module tb_mlp_stream_engine;

    localparam int D_IN  = 2;
    localparam int D_HID = 2;
    localparam int DW    = 16;
    localparam int NW    = D_HID * (D_IN + 1) + D_IN * (D_HID + 1);
    localparam int JOB_LIMIT = 400;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    act_mode;
    logic          in_valid, in_ready, w_valid, w_ready, out_valid, out_ready, busy, done;
    logic [DW-1:0] in_data, w_data, out_data;

    logic [15:0] xv [D_IN];
    logic [15:0] w1 [D_HID][D_IN];
    logic [15:0] b1 [D_HID];
    logic [15:0] w2 [D_IN][D_HID];
    logic [15:0] b2 [D_IN];
    logic [1:0]  job_act;
    logic [15:0] exp_q [$];
    int          n_checks, n_pass;
    int          base_cyc, tog_cyc, dummy_cyc;

    always #5 clk = ~clk;

    mlp_stream_engine #(
        .D_IN       (D_IN),
        .D_HID      (D_HID),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .act_mode  (act_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] rnd_sat(input longint acc, input logic [15:0] b);
        longint s;
        s = acc + longint'($signed(b)) * 32768 + 64'sd16384;
        s = s >>> 15;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    task automatic push_expected();
        logic [15:0] h [D_HID];
        longint acc;
        for (int j = 0; j < D_HID; j++) begin
            acc = 0;
            for (int k = 0; k < D_IN; k++)
                acc += longint'($signed(w1[j][k])) * longint'($signed(xv[k]));
            h[j] = rnd_sat(acc, b1[j]);
            if ((job_act == 2'd1 || job_act == 2'd3) && h[j][15])
                h[j] = 16'h0000;
            else if (job_act == 2'd2 && h[j][15])
                h[j] = $signed(h[j]) >>> 3;
        end
        for (int i = 0; i < D_IN; i++) begin
            acc = 0;
            for (int k = 0; k < D_HID; k++)
                acc += longint'($signed(w2[i][k])) * longint'($signed(h[k]));
            exp_q.push_back(rnd_sat(acc, b2[i]));
        end
    endtask

    task automatic set_diag(input logic [15:0] x0, input logic [15:0] x1);
        xv[0] = x0;
        xv[1] = x1;
        for (int j = 0; j < 2; j++) begin
            b1[j] = 16'h0000;
            b2[j] = 16'h0000;
            for (int k = 0; k < 2; k++) begin
                w1[j][k] = (j == k) ? 16'h4000 : 16'h0000;
                w2[j][k] = (j == k) ? 16'h4000 : 16'h0000;
            end
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},  32'(in_ready),  0);
        check({pfx, "_w_ready"},   32'(w_ready),   0);
        check({pfx, "_out_valid"}, 32'(out_valid), 0);
        check({pfx, "_out_data"},  32'(out_data),  0);
        check({pfx, "_busy"},      32'(busy),      0);
        check({pfx, "_done"},      32'(done),      0);
    endtask

    // Runs one job from IDLE; all driving and sampling happens on the falling edge.
    task automatic run_job(input bit toggle_w, input int stall, output int cycles);
        logic [15:0] ws [$];
        logic [15:0] e;
        int xp, wp, ny, dones, stall_left, stall_wbeats, cyc;
        bit fin, stalled;
        ws = {};
        for (int j = 0; j < D_HID; j++) begin
            for (int k = 0; k < D_IN; k++) ws.push_back(w1[j][k]);
            ws.push_back(b1[j]);
        end
        for (int i = 0; i < D_IN; i++) begin
            for (int k = 0; k < D_HID; k++) ws.push_back(w2[i][k]);
            ws.push_back(b2[i]);
        end
        push_expected();
        @(negedge clk);
        start = 1'b1;
        act_mode = job_act;
        @(negedge clk);
        start = 1'b0;
        xp = 0; wp = 0; ny = 0; dones = 0; cyc = 0; stall_wbeats = 0;
        stall_left = stall;
        fin = 1'b0;
        while (!fin && cyc < JOB_LIMIT) begin
            in_valid = (xp < D_IN);
            in_data  = in_valid ? xv[xp] : '0;
            w_valid  = (wp < NW) && (!toggle_w || cyc[0]);
            w_data   = (wp < NW) ? ws[wp] : '0;
            stalled  = out_valid && ny == 0 && stall_left > 0;
            out_ready = !stalled;
            if (stalled) begin
                stall_left--;
                check("stall_w_ready", 32'(w_ready), 0);
                if (exp_q.size() > 0) check("stall_out_data", 32'(out_data), 32'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("y%0d", ny), 32'(out_data), 32'(e));
                end else begin
                    check("extra_y", 32'(out_valid), 0);
                end
                ny++;
            end
            if (in_valid && in_ready) xp++;
            if (w_valid && w_ready) begin
                wp++;
                if (stalled) stall_wbeats++;
            end
            if (done) begin
                dones++;
                fin = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        w_valid = 1'b0;
        out_ready = 1'b1;
        check("job_timeout", 32'(fin), 1);
        repeat (3) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("done_pulses", 32'(dones), 1);
        check("y_count", 32'(ny), D_IN);
        check("w_consumed", 32'(wp), NW);
        check("busy_after", 32'(busy), 0);
        if (stall > 0) check("stall_wbeats", 32'(stall_wbeats), 0);
        exp_q = {};
        cycles = cyc;
    endtask

    // Starts a job and hits rst part way through the first layer.
    task automatic abort_in_fc1();
        int xp, wp, cyc;
        @(negedge clk);
        start = 1'b1;
        act_mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        xp = 0; wp = 0; cyc = 0;
        while (wp < 3 && cyc < 100) begin
            in_valid = (xp < D_IN);
            in_data  = in_valid ? xv[xp] : '0;
            w_valid  = 1'b1;
            w_data   = 16'h4000;
            if (in_valid && in_ready) xp++;
            if (w_valid && w_ready) wp++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        w_valid = 1'b0;
        check("abort_reached_fc1", 32'(wp), 3);
        check("abort_w_ready", 32'(w_ready), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; act_mode = 2'd0;
        in_valid = 1'b0; in_data = '0; w_valid = 1'b0; w_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        set_diag(16'h2000, 16'h1000); job_act = 2'd0;
        run_job(1'b0, 0, base_cyc);

        set_diag(16'hC000, 16'h4000);
        for (int a = 1; a < 4; a++) begin
            job_act = 2'(a);
            run_job(1'b0, 0, dummy_cyc);
        end

        xv[0] = 16'h7FFF; xv[1] = 16'h7FFF; job_act = 2'd0;
        for (int j = 0; j < 2; j++) begin
            b1[j] = 16'h7FFF; b2[j] = 16'h7FFF;
            for (int k = 0; k < 2; k++) begin
                w1[j][k] = 16'h7FFF; w2[j][k] = 16'h7FFF;
            end
        end
        run_job(1'b0, 0, dummy_cyc);
        // A positive b2 leaves this at 0x8003; a negative b2 drives it into the lower clamp.
        for (int j = 0; j < 2; j++) begin
            b2[j] = 16'h8000;
            for (int k = 0; k < 2; k++) w2[j][k] = 16'h8001;
        end
        run_job(1'b0, 0, dummy_cyc);

        set_diag(16'h2000, 16'h1000); job_act = 2'd0;
        run_job(1'b0, 10, dummy_cyc);
        run_job(1'b1, 0, tog_cyc);
        check("toggle_cycles", 32'(tog_cyc > base_cyc + 8), 1);

        abort_in_fc1();
        set_diag(16'h2000, 16'h1000); job_act = 2'd0;
        run_job(1'b0, 0, dummy_cyc);

        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 2; j++) begin
                xv[j] = 16'($urandom);
                b1[j] = 16'($urandom);
                b2[j] = 16'($urandom_range(0, 16'h0FFF));
                for (int k = 0; k < 2; k++) begin
                    w1[j][k] = 16'($urandom);
                    w2[j][k] = 16'($urandom_range(0, 16'h3FFF));
                end
            end
            job_act = 2'($urandom_range(0, 3));
            run_job(1'(t & 1), 0, dummy_cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
